lu_rr_arbiter: RTL and testbench

//  Shares one 16-bit bitwise logic unit (OR/AND/XOR/NOR) among NREQ requesters.

---
 rtl/lu_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_lu_rr_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lu_rr_arbiter.sv
// Round-robin arbiter sharing one 16-bit bitwise logic unit (OR/AND/XOR/NOR) among NREQ requesters.
// Optional feature: define LU_GRANT_CNT_EN to add a saturating transfer counter (grant_cnt, cnt_clr).
module lu_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [2*NREQ-1:0] req_op,
    input  logic [W*NREQ-1:0] req_x,
    input  logic [W*NREQ-1:0] req_y,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_data,
    output logic [IDW-1:0]    res_id,
    output logic              res_zero
`ifdef LU_GRANT_CNT_EN
    ,
    input  logic              cnt_clr,
    output logic [15:0]       grant_cnt
`endif
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                   state_reg, state_next;
    logic [IDW-1:0]           last_reg, last_next;
    logic [W-1:0]             data_reg, data_next;
    logic [IDW-1:0]           id_reg, id_next;
    logic [NREQ-1:0][W-1:0]   op_res;
    logic [IDW-1:0]           winner;
    logic [W-1:0]             winner_res;
    logic                     found;
    logic                     can_accept;
    logic                     transfer;
    int                       idx;

    function automatic logic [W-1:0] lu_op(input logic [1:0] op, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        case (op)
            2'b00:   lu_op = x | y;
            2'b01:   lu_op = x & y;
            2'b10:   lu_op = x ^ y;
            default: lu_op = ~(x | y);
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lu
            assign op_res[gi] = lu_op(req_op[2*gi +: 2], req_x[W*gi +: W], req_y[W*gi +: W]);
        end
    endgenerate

    // Rotating priority: the requester just after the last winner is searched first.
    always_comb begin
        winner     = '0;
        winner_res = '0;
        found      = 1'b0;
        idx        = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_reg) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                winner     = IDW'(idx);
                winner_res = op_res[idx];
            end
        end
    end

    assign can_accept = rst_n & ((state_reg == EMPTY) | res_ready);
    assign transfer   = found & can_accept;
    assign req_ready  = transfer ? (NREQ'(1) << winner) : '0;

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        data_next  = data_reg;
        id_next    = id_reg;
        case (state_reg)
            EMPTY:   if (transfer) state_next = FULL;
            FULL:    if (!transfer && res_ready) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
        if (transfer) begin
            data_next = winner_res;
            id_next   = winner;
            last_next = winner;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            last_reg  <= IDW'(NREQ - 1);
            data_reg  <= '0;
            id_reg    <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            data_reg  <= data_next;
            id_reg    <= id_next;
        end
    end

    assign res_valid = (state_reg == FULL);
    assign res_data  = data_reg;
    assign res_id    = id_reg;
    assign res_zero  = (data_reg == '0);

`ifdef LU_GRANT_CNT_EN
    logic [15:0] cnt_reg;

    // Clear takes priority over a same-cycle transfer.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_reg <= '0;
        else if (cnt_clr)
            cnt_reg <= '0;
        else if (transfer && cnt_reg != 16'hFFFF)
            cnt_reg <= cnt_reg + 16'd1;
    end

    assign grant_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_lu_rr_arbiter.sv
// Directed self-checking bench for lu_rr_arbiter (NREQ=4, W=16); counter test runs when LU_GRANT_CNT_EN is defined.
module tb_lu_rr_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [2*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_x;
    logic [W*NREQ-1:0] req_y;
    logic              res_valid;
    logic              res_ready;
    logic [W-1:0]      res_data;
    logic [IDW-1:0]    res_id;
    logic              res_zero;
`ifdef LU_GRANT_CNT_EN
    logic              cnt_clr;
    logic [15:0]       grant_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lu_rr_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_x     (req_x),
        .req_y     (req_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_zero  (res_zero)
`ifdef LU_GRANT_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .grant_cnt (grant_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] x,
                           input logic [W-1:0] y);
        req_op[2*i +: 2] = op;
        req_x[W*i +: W]  = x;
        req_y[W*i +: W]  = y;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        res_ready = 1'b1;
        req_op    = '0;
        req_x     = '0;
        req_y     = '0;
`ifdef LU_GRANT_CNT_EN
        cnt_clr = 1'b0;
`endif
        tick();
        tick();
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready);
        end
        n_checks++;
        if (res_valid !== 1'b0 || res_zero !== 1'b1 || res_data !== 16'h0 || res_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got valid=%b zero=%b data=%h id=%0d exp 0 1 0000 0",
                     res_valid, res_zero, res_data, res_id);
        end
        $display("reset: ready=%b valid=%b zero=%b", req_ready, res_valid, res_zero);
        req_valid = '0;
        rst_n     = 1'b1;
        tick();
    endtask

    task automatic test_single_op();
        res_ready = 1'b1;
        set_req(2, 2'b10, 16'hF0F0, 16'hFF00);
        req_valid = 4'b0100;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL single_ready got=%b exp=0100", req_ready);
        end
        tick();
        req_valid = '0;
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 16'h0FF0 || res_id !== 2'd2 || res_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL single_result got valid=%b data=%h id=%0d zero=%b exp 1 0ff0 2 0",
                     res_valid, res_data, res_id, res_zero);
        end
        $display("single: data=%h id=%0d", res_data, res_id);
        tick();
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_drain got valid=%b exp=0", res_valid);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 2'b00, W'(i), 16'h0000);
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            logic [NREQ-1:0] exp_ready;
            exp_ready = 4'b0001 << (k % 4);
            #1;
            n_checks++;
            if (req_ready !== exp_ready) begin
                n_fail++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, exp_ready);
            end
            tick();
            n_checks++;
            if (res_valid !== 1'b1 || res_id !== IDW'(k % 4) || res_data !== W'(k % 4)) begin
                n_fail++;
                $display("FAIL rr_result[%0d] got valid=%b id=%0d data=%h exp 1 %0d %0d",
                         k, res_valid, res_id, res_data, k % 4, k % 4);
            end
            $display("rr[%0d]: id=%0d data=%h", k, res_id, res_data);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        res_ready = 1'b1;
        set_req(1, 2'b01, 16'h1234, 16'h00FF);
        req_valid = 4'b0010;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL bp_first_ready got=%b exp=0010", req_ready);
        end
        tick();
        res_ready = 1'b0;
        set_req(1, 2'b01, 16'h5678, 16'hFFFF);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0000) begin
                n_fail++; $display("FAIL bp_ready[%0d] got=%b exp=0000", c, req_ready);
            end
            tick();
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== 16'h0034 || res_id !== 2'd1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got valid=%b data=%h id=%0d exp 1 0034 1",
                         c, res_valid, res_data, res_id);
            end
            $display("bp[%0d]: held data=%h", c, res_data);
        end
        res_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL bp_release_ready got=%b exp=0010", req_ready);
        end
        tick();
        req_valid = '0;
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 16'h5678 || res_id !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_new got valid=%b data=%h id=%0d exp 1 5678 1", res_valid, res_data, res_id);
        end
        $display("bp release: data=%h", res_data);
        tick();
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain got valid=%b exp=0", res_valid);
        end
    endtask

    task automatic test_nor_zero();
        res_ready = 1'b1;
        set_req(0, 2'b11, 16'hFFFF, 16'h0000);
        req_valid = 4'b0001;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL nor_ready got=%b exp=0001", req_ready);
        end
        tick();
        n_checks++;
        if (res_data !== 16'h0000 || res_zero !== 1'b1 || res_id !== 2'd0) begin
            n_fail++;
            $display("FAIL nor_zero got data=%h zero=%b id=%0d exp 0000 1 0", res_data, res_zero, res_id);
        end
        $display("nor: data=%h zero=%b", res_data, res_zero);
        set_req(0, 2'b11, 16'h0000, 16'h0000);
        tick();
        n_checks++;
        if (res_data !== 16'hFFFF || res_zero !== 1'b0) begin
            n_fail++; $display("FAIL nor_ones got data=%h zero=%b exp ffff 0", res_data, res_zero);
        end
        $display("nor: data=%h zero=%b", res_data, res_zero);
        set_req(0, 2'b01, 16'hAAAA, 16'h5555);
        tick();
        req_valid = '0;
        n_checks++;
        if (res_data !== 16'h0000 || res_zero !== 1'b1) begin
            n_fail++; $display("FAIL and_zero got data=%h zero=%b exp 0000 1", res_data, res_zero);
        end
        $display("and: data=%h zero=%b", res_data, res_zero);
        tick();
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b0;
        set_req(3, 2'b10, 16'h0001, 16'h0000);
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 16'h0001 || res_id !== 2'd3) begin
            n_fail++;
            $display("FAIL mid_load got valid=%b data=%h id=%0d exp 1 0001 3", res_valid, res_data, res_id);
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (res_valid !== 1'b0 || res_data !== 16'h0 || res_id !== 2'd0 || res_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset got valid=%b data=%h id=%0d zero=%b exp 0 0000 0 1",
                     res_valid, res_data, res_id, res_zero);
        end
        $display("mid reset: valid=%b", res_valid);
        rst_n     = 1'b1;
        res_ready = 1'b1;
        tick();
    endtask

`ifdef LU_GRANT_CNT_EN
    task automatic test_grant_cnt();
        apply_reset();
        n_checks++;
        if (grant_cnt !== 16'h0) begin
            n_fail++; $display("FAIL cnt_reset got=%h exp=0000", grant_cnt);
        end
        res_ready = 1'b1;
        cnt_clr   = 1'b0;
        set_req(0, 2'b00, 16'h0001, 16'h0000);
        req_valid = 4'b0001;
        for (int c = 0; c < 70000; c++) tick();
        n_checks++;
        if (grant_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL cnt_saturate got=%h exp=ffff", grant_cnt);
        end
        $display("cnt after 70000: %h", grant_cnt);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_checks++;
        if (grant_cnt !== 16'h0) begin
            n_fail++; $display("FAIL cnt_clear got=%h exp=0000", grant_cnt);
        end
        tick();
        req_valid = '0;
        n_checks++;
        if (grant_cnt !== 16'h1) begin
            n_fail++; $display("FAIL cnt_resume got=%h exp=0001", grant_cnt);
        end
        $display("cnt after clear+1: %h", grant_cnt);
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_nor_zero();
        test_reset_mid();
`ifdef LU_GRANT_CNT_EN
        test_grant_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
